// File: rtl/chroma_key_pkg.sv
// Shared mode encoding and default widths for the chroma-key compositor.
package chroma_key_pkg;

    localparam int unsigned DEF_COLOR_W = 10;
    localparam int unsigned DEF_COUNT_W = 22;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_BG     = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_MASK   = 2'd3
    } mode_e;

endpackage

// File: rtl/chroma_key_mixer_if.sv
// Pixel-stream bundle: foreground/background input pixels and the composited output pixel.
interface chroma_key_mixer_if
    import chroma_key_pkg::*;
#(
    parameter int unsigned COLOR_W = DEF_COLOR_W
);
    logic [COLOR_W-1:0] fg_r, fg_g, fg_b;
    logic [COLOR_W-1:0] bg_r, bg_g, bg_b;
    logic               valid, sof;
    logic [COLOR_W-1:0] out_r, out_g, out_b;
    logic               out_valid, out_keyed;

    modport master (
        output fg_r, fg_g, fg_b, bg_r, bg_g, bg_b, valid, sof,
        input  out_r, out_g, out_b, out_valid, out_keyed
    );

    modport slave (
        input  fg_r, fg_g, fg_b, bg_r, bg_g, bg_b, valid, sof,
        output out_r, out_g, out_b, out_valid, out_keyed
    );
endinterface

// File: rtl/chroma_key_detect.sv
// Combinational green-screen test plus spill-corrected green for one pixel.
module chroma_key_detect #(
    parameter int unsigned COLOR_W = 10
) (
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    input  logic [COLOR_W-1:0] i_g_min,
    input  logic [COLOR_W-1:0] i_margin,
    output logic               o_keyed,
    output logic [COLOR_W-1:0] o_g_spill
);
    logic [COLOR_W:0]   w_g_wide;
    logic [COLOR_W:0]   w_r_margin;
    logic [COLOR_W:0]   w_b_margin;
    logic [COLOR_W-1:0] w_rb_max;

    // One extra bit so channel + margin never wraps.
    assign w_g_wide   = {1'b0, i_g};
    assign w_r_margin = {1'b0, i_r} + {1'b0, i_margin};
    assign w_b_margin = {1'b0, i_b} + {1'b0, i_margin};

    assign o_keyed = (i_g >= i_g_min) && (w_g_wide >= w_r_margin) && (w_g_wide >= w_b_margin);

    assign w_rb_max  = (i_r > i_b) ? i_r : i_b;
    assign o_g_spill = (o_keyed || (i_g <= w_rb_max)) ? i_g : w_rb_max;
endmodule

// File: rtl/chroma_key_mixer.sv
// Three-stage chroma-key compositor with start-of-frame config shadowing and a per-frame keyed-pixel counter.
module chroma_key_mixer
    import chroma_key_pkg::*;
#(
    parameter int unsigned COLOR_W = DEF_COLOR_W,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iFG_R,
    input  logic [COLOR_W-1:0] iFG_G,
    input  logic [COLOR_W-1:0] iFG_B,
    input  logic [COLOR_W-1:0] iBG_R,
    input  logic [COLOR_W-1:0] iBG_G,
    input  logic [COLOR_W-1:0] iBG_B,
    input  logic               iVALID,
    input  logic               iSOF,
    input  logic [1:0]         iMODE,
    input  logic [COLOR_W-1:0] iKEY_G_MIN,
    input  logic [COLOR_W-1:0] iMARGIN,
    input  logic [COLOR_W-1:0] iFILL_R,
    input  logic [COLOR_W-1:0] iFILL_G,
    input  logic [COLOR_W-1:0] iFILL_B,
    input  logic               iSPILL_EN,
    output logic [COLOR_W-1:0] oR,
    output logic [COLOR_W-1:0] oG,
    output logic [COLOR_W-1:0] oB,
    output logic               oVALID,
    output logic               oKEYED,
    output logic [COUNT_W-1:0] oKEY_COUNT,
    output logic               oFRAME_DONE
);
    logic               w_load;
    mode_e              w_mode, r_sh_mode, r1_mode, r2_mode;
    logic [COLOR_W-1:0] w_gmin, w_margin, w_fill_r, w_fill_g, w_fill_b;
    logic               w_spill;
    logic [COLOR_W-1:0] r_sh_gmin, r_sh_margin, r_sh_fill_r, r_sh_fill_g, r_sh_fill_b;
    logic               r_sh_spill;

    logic               r1_valid, r1_sof, r1_spill;
    logic [COLOR_W-1:0] r1_fg_r, r1_fg_g, r1_fg_b, r1_bg_r, r1_bg_g, r1_bg_b;
    logic [COLOR_W-1:0] r1_gmin, r1_margin, r1_fill_r, r1_fill_g, r1_fill_b;

    logic               w_keyed;
    logic [COLOR_W-1:0] w_g_spill;

    logic               r2_valid, r2_sof, r2_keyed;
    logic [COLOR_W-1:0] r2_fg_r, r2_fg_g, r2_fg_b, r2_bg_r, r2_bg_g, r2_bg_b;
    logic [COLOR_W-1:0] r2_fill_r, r2_fill_g, r2_fill_b;

    logic [COLOR_W-1:0] w_r, w_g, w_b;
    logic [COUNT_W-1:0] r_acc;
    logic               r_armed;

    // The SOF pixel itself uses the values being loaded into the shadow.
    assign w_load = iVALID && iSOF;

    always_comb begin
        w_mode   = r_sh_mode;
        w_gmin   = r_sh_gmin;
        w_margin = r_sh_margin;
        w_fill_r = r_sh_fill_r;
        w_fill_g = r_sh_fill_g;
        w_fill_b = r_sh_fill_b;
        w_spill  = r_sh_spill;
        if (w_load) begin
            w_mode   = mode_e'(iMODE);
            w_gmin   = iKEY_G_MIN;
            w_margin = iMARGIN;
            w_fill_r = iFILL_R;
            w_fill_g = iFILL_G;
            w_fill_b = iFILL_B;
            w_spill  = iSPILL_EN;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r1_valid    <= 1'b0;
            r1_sof      <= 1'b0;
            r_sh_mode   <= MODE_BYPASS;
            r_sh_gmin   <= '0;
            r_sh_margin <= '0;
            r_sh_fill_r <= '0;
            r_sh_fill_g <= '0;
            r_sh_fill_b <= '0;
            r_sh_spill  <= 1'b0;
        end else begin
            r1_valid    <= iVALID;
            r1_sof      <= w_load;
            r_sh_mode   <= w_mode;
            r_sh_gmin   <= w_gmin;
            r_sh_margin <= w_margin;
            r_sh_fill_r <= w_fill_r;
            r_sh_fill_g <= w_fill_g;
            r_sh_fill_b <= w_fill_b;
            r_sh_spill  <= w_spill;
        end
    end

    always_ff @(posedge iCLK) begin
        r1_fg_r   <= iFG_R;
        r1_fg_g   <= iFG_G;
        r1_fg_b   <= iFG_B;
        r1_bg_r   <= iBG_R;
        r1_bg_g   <= iBG_G;
        r1_bg_b   <= iBG_B;
        r1_mode   <= w_mode;
        r1_gmin   <= w_gmin;
        r1_margin <= w_margin;
        r1_fill_r <= w_fill_r;
        r1_fill_g <= w_fill_g;
        r1_fill_b <= w_fill_b;
        r1_spill  <= w_spill;
    end

    chroma_key_detect #(.COLOR_W(COLOR_W)) u_detect (
        .i_r       (r1_fg_r),
        .i_g       (r1_fg_g),
        .i_b       (r1_fg_b),
        .i_g_min   (r1_gmin),
        .i_margin  (r1_margin),
        .o_keyed   (w_keyed),
        .o_g_spill (w_g_spill)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r2_valid <= 1'b0;
            r2_sof   <= 1'b0;
        end else begin
            r2_valid <= r1_valid;
            r2_sof   <= r1_sof;
        end
    end

    always_ff @(posedge iCLK) begin
        r2_keyed  <= w_keyed;
        r2_fg_r   <= r1_fg_r;
        r2_fg_g   <= r1_spill ? w_g_spill : r1_fg_g;
        r2_fg_b   <= r1_fg_b;
        r2_bg_r   <= r1_bg_r;
        r2_bg_g   <= r1_bg_g;
        r2_bg_b   <= r1_bg_b;
        r2_fill_r <= r1_fill_r;
        r2_fill_g <= r1_fill_g;
        r2_fill_b <= r1_fill_b;
        r2_mode   <= r1_mode;
    end

    always_comb begin
        w_r = r2_fg_r;
        w_g = r2_fg_g;
        w_b = r2_fg_b;
        unique case (r2_mode)
            MODE_BG: if (r2_keyed) begin
                w_r = r2_bg_r;
                w_g = r2_bg_g;
                w_b = r2_bg_b;
            end
            MODE_FILL: if (r2_keyed) begin
                w_r = r2_fill_r;
                w_g = r2_fill_g;
                w_b = r2_fill_b;
            end
            MODE_MASK: begin
                w_r = r2_keyed ? '1 : '0;
                w_g = r2_keyed ? '1 : '0;
                w_b = r2_keyed ? '1 : '0;
            end
            default: ;
        endcase
    end

    // Bubbles leave zeros on the pixel outputs; the first SOF only arms the frame counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oR          <= '0;
            oG          <= '0;
            oB          <= '0;
            oVALID      <= 1'b0;
            oKEYED      <= 1'b0;
            oKEY_COUNT  <= '0;
            oFRAME_DONE <= 1'b0;
            r_acc       <= '0;
            r_armed     <= 1'b0;
        end else begin
            oR          <= r2_valid ? w_r : '0;
            oG          <= r2_valid ? w_g : '0;
            oB          <= r2_valid ? w_b : '0;
            oVALID      <= r2_valid;
            oKEYED      <= r2_valid && r2_keyed;
            oFRAME_DONE <= 1'b0;
            if (r2_valid) begin
                if (r2_sof) begin
                    r_acc   <= {{(COUNT_W-1){1'b0}}, r2_keyed};
                    r_armed <= 1'b1;
                    if (r_armed) begin
                        oKEY_COUNT  <= r_acc;
                        oFRAME_DONE <= 1'b1;
                    end
                end else if (r2_keyed && (r_acc != '1)) begin
                    r_acc <= r_acc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_chroma_key_mixer.sv
// Directed bench for chroma_key_mixer: vector table plus reset, counter and shadowing sequences.
module tb_chroma_key_mixer;
    localparam int unsigned CW = 10;
    localparam int unsigned NW = 22;

    typedef struct {
        logic       v;
        logic       sof;
        logic [1:0] mode;
        logic [CW-1:0] gmin, margin;
        logic       spill;
        logic [CW-1:0] r, g, b, br, bg, bb;
        logic [CW-1:0] er, eg, eb;
        logic       ek;
        logic       cd;
        logic       ed;
        int         ec;
        int         id;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] mode;
    logic [CW-1:0] gmin, margin;
    logic [CW-1:0] fill_r, fill_g, fill_b;
    logic spill;
    logic [NW-1:0] kcount;
    logic fdone;
    logic [CW-1:0] d2_r, d2_g, d2_b;
    logic d2_valid, d2_keyed, d2_done;
    logic [1:0] d2_count;

    int errors = 0;
    int checks = 0;
    string section;
    vec_t pipe[3];
    logic pz[3];
    vec_t tab[13];

    always #5 clk = ~clk;

    chroma_key_mixer_if #(.COLOR_W(CW)) bus ();

    chroma_key_mixer #(.COLOR_W(CW), .COUNT_W(NW)) dut (
        .iCLK(clk), .iRST(rst),
        .iFG_R(bus.fg_r), .iFG_G(bus.fg_g), .iFG_B(bus.fg_b),
        .iBG_R(bus.bg_r), .iBG_G(bus.bg_g), .iBG_B(bus.bg_b),
        .iVALID(bus.valid), .iSOF(bus.sof), .iMODE(mode),
        .iKEY_G_MIN(gmin), .iMARGIN(margin),
        .iFILL_R(fill_r), .iFILL_G(fill_g), .iFILL_B(fill_b), .iSPILL_EN(spill),
        .oR(bus.out_r), .oG(bus.out_g), .oB(bus.out_b),
        .oVALID(bus.out_valid), .oKEYED(bus.out_keyed),
        .oKEY_COUNT(kcount), .oFRAME_DONE(fdone)
    );

    chroma_key_mixer #(.COLOR_W(CW), .COUNT_W(2)) dut_sat (
        .iCLK(clk), .iRST(rst),
        .iFG_R(bus.fg_r), .iFG_G(bus.fg_g), .iFG_B(bus.fg_b),
        .iBG_R(bus.bg_r), .iBG_G(bus.bg_g), .iBG_B(bus.bg_b),
        .iVALID(bus.valid), .iSOF(bus.sof), .iMODE(mode),
        .iKEY_G_MIN(gmin), .iMARGIN(margin),
        .iFILL_R(fill_r), .iFILL_G(fill_g), .iFILL_B(fill_b), .iSPILL_EN(spill),
        .oR(d2_r), .oG(d2_g), .oB(d2_b),
        .oVALID(d2_valid), .oKEYED(d2_keyed),
        .oKEY_COUNT(d2_count), .oFRAME_DONE(d2_done)
    );

    function automatic vec_t px(input logic sof, input int md, input int gm, input int mg,
                                input logic sp, input int r, input int g, input int b,
                                input int br, input int bg, input int bb,
                                input int er, input int eg, input int eb, input logic ek);
        vec_t t;
        t.v = 1'b1; t.sof = sof; t.mode = md[1:0];
        t.gmin = gm[CW-1:0]; t.margin = mg[CW-1:0]; t.spill = sp;
        t.r = r[CW-1:0]; t.g = g[CW-1:0]; t.b = b[CW-1:0];
        t.br = br[CW-1:0]; t.bg = bg[CW-1:0]; t.bb = bb[CW-1:0];
        t.er = er[CW-1:0]; t.eg = eg[CW-1:0]; t.eb = eb[CW-1:0]; t.ek = ek;
        t.cd = 1'b0; t.ed = 1'b0; t.ec = 0; t.id = 0;
        return t;
    endfunction

    function automatic vec_t bub();
        vec_t t = px(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        t.v = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s #%0d: got %0h, expected %0h", section, name, id, act, exp);
        end
    endtask

    task automatic check_out(input vec_t e, input logic z);
        chk("valid", e.id, {31'd0, bus.out_valid}, {31'd0, e.v});
        if (e.v) begin
            chk("rgb", e.id, {2'd0, bus.out_r, bus.out_g, bus.out_b}, {2'd0, e.er, e.eg, e.eb});
            chk("keyed", e.id, {31'd0, bus.out_keyed}, {31'd0, e.ek});
        end else if (z) begin
            chk("rgb_zero", e.id, {2'd0, bus.out_r, bus.out_g, bus.out_b}, 32'd0);
            chk("keyed_zero", e.id, {31'd0, bus.out_keyed}, 32'd0);
        end
        if (e.cd) begin
            chk("frame_done", e.id, {31'd0, fdone}, {31'd0, e.ed});
            if (e.ed) begin
                chk("key_count", e.id, {10'd0, kcount}, e.ec);
                chk("sat_count", e.id, {30'd0, d2_count}, (e.ec > 3) ? 3 : e.ec);
            end
        end
    endtask

    // Check the output due this cycle, advance the expectation pipe, then drive the next input.
    task automatic step(input vec_t x, input logic r);
        @(negedge clk);
        check_out(pipe[2], pz[2]);
        pipe[2] = pipe[1]; pz[2] = pz[1];
        pipe[1] = pipe[0]; pz[1] = pz[0];
        pipe[0] = x;       pz[0] = 1'b0;
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                pipe[k] = bub();
                pz[k] = 1'b1;
            end
        end
        rst = r;
        bus.valid = x.v; bus.sof = x.sof;
        mode = x.mode; gmin = x.gmin; margin = x.margin; spill = x.spill;
        bus.fg_r = x.r; bus.fg_g = x.g; bus.fg_b = x.b;
        bus.bg_r = x.br; bus.bg_g = x.bg; bus.bg_b = x.bb;
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) step(bub(), 1'b0);
    endtask

    initial begin
        vec_t t;
        fill_r = 10'd1; fill_g = 10'd2; fill_b = 10'd3;
        rst = 1'b1;
        bus.valid = 1'b0; bus.sof = 1'b0;
        mode = 2'd0; gmin = '0; margin = '0; spill = 1'b0;
        bus.fg_r = '0; bus.fg_g = '0; bus.fg_b = '0;
        bus.bg_r = '0; bus.bg_g = '0; bus.bg_b = '0;

        //          sof  md  gmin  mrg  sp   fg             bg          expected         k
        tab[0]  = px(1, 1,  512, 100, 0, 100, 700, 100,  5,  6,  7,    5,   6,   7, 1);
        tab[1]  = px(1, 1,  512, 100, 0, 600, 700, 100, 11, 22, 33,   11,  22,  33, 1);
        tab[2]  = px(1, 1,  512, 100, 0, 601, 700, 100, 11, 22, 33,  601, 700, 100, 0);
        tab[3]  = px(1, 0, 1023, 100, 1, 300, 500, 200,  0,  0,  0,  300, 300, 200, 0);
        tab[4]  = px(1, 0,  100,   0, 1,  10, 900,  20,  0,  0,  0,   10, 900,  20, 1);
        tab[5]  = px(1, 2,  512, 100, 0, 100, 700, 100,  9,  9,  9,    1,   2,   3, 1);
        tab[6]  = px(1, 2,  512, 100, 0, 400, 450,  10,  9,  9,  9,  400, 450,  10, 0);
        tab[7]  = px(1, 3, 1023,1023, 0,   0,1023,   0,  9,  9,  9, 1023,1023,1023, 1);
        tab[8]  = px(1, 3, 1023,1023, 0,   5,1023,   0,  9,  9,  9,    0,   0,   0, 0);
        tab[9]  = px(1, 1,  512, 100, 1, 200, 250, 100,  9,  9,  9,  200, 200, 100, 0);
        tab[10] = px(1, 0, 1023, 100, 1, 300, 100,  50,  9,  9,  9,  300, 100,  50, 0);
        tab[11] = px(1, 1,  700, 100, 0, 100, 700, 100,  5,  6,  7,    5,   6,   7, 1);
        tab[12] = px(1, 1,  701, 100, 0, 100, 700, 100,  5,  6,  7,  100, 700, 100, 0);
        for (int i = 0; i < 13; i++) tab[i].id = i;

        section = "reset";
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("oR", 0, {22'd0, bus.out_r}, 32'd0);
        chk("oG", 0, {22'd0, bus.out_g}, 32'd0);
        chk("oB", 0, {22'd0, bus.out_b}, 32'd0);
        chk("oVALID", 0, {31'd0, bus.out_valid}, 32'd0);
        chk("oKEYED", 0, {31'd0, bus.out_keyed}, 32'd0);
        chk("oKEY_COUNT", 0, {10'd0, kcount}, 32'd0);
        chk("oFRAME_DONE", 0, {31'd0, fdone}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            pipe[k] = bub();
            pz[k] = 1'b1;
        end

        section = "table";
        for (int i = 0; i < 13; i++) step(tab[i], 1'b0);
        flush();

        section = "midreset";
        t = px(1, 1, 512, 100, 0, 100, 700, 100, 9, 9, 9, 9, 9, 9, 1); t.id = 0;
        step(t, 1'b0);
        step(bub(), 1'b0);
        t = px(0, 1, 512, 100, 0, 100, 700, 100, 9, 9, 9, 9, 9, 9, 1); t.id = 1;
        step(t, 1'b0);
        t = px(1, 1, 512, 100, 0, 100, 700, 100, 9, 9, 9, 9, 9, 9, 1); t.id = 2;
        t.cd = 1'b1; t.ed = 1'b1; t.ec = 2;
        step(t, 1'b0);
        step(bub(), 1'b0);
        step(bub(), 1'b0);
        t = px(0, 1, 512, 100, 0, 100, 700, 100, 9, 9, 9, 9, 9, 9, 1); t.id = 3;
        step(t, 1'b1);
        step(bub(), 1'b1);
        chk("count_after_reset", 0, {10'd0, kcount}, 32'd0);
        chk("done_after_reset", 0, {31'd0, fdone}, 32'd0);
        // Non-SOF pixels after reset run with the all-zero shadow (bypass, G_MIN=0, MARGIN=0).
        t = px(0, 3, 1023, 1023, 1, 100, 700, 100, 9, 9, 9, 100, 700, 100, 1); t.id = 4;
        step(t, 1'b0);
        t = px(0, 3, 1023, 1023, 1, 300, 500, 600, 9, 9, 9, 300, 500, 600, 0); t.id = 5;
        step(t, 1'b0);
        t = px(1, 3, 512, 100, 0, 100, 700, 100, 9, 9, 9, 1023, 1023, 1023, 1); t.id = 6;
        step(t, 1'b0);
        t = px(0, 1, 512, 100, 0, 700, 700, 700, 9, 9, 9, 0, 0, 0, 0); t.id = 7;
        step(t, 1'b0);
        flush();

        section = "counter";
        step(bub(), 1'b1);
        step(bub(), 1'b1);
        for (int j = 0; j < 25; j++) begin
            logic k;
            k = ((j % 8) < 5);
            if (k) t = px((j % 8) == 0, 1, 512, 100, 0, 100, 700, 100, 7, 8, 9, 7, 8, 9, 1);
            else   t = px((j % 8) == 0, 1, 512, 100, 0, 700, 700, 700, 7, 8, 9, 700, 700, 700, 0);
            t.id = j; t.cd = 1'b1; t.ed = ((j % 8) == 0) && (j >= 8); t.ec = 5;
            step(t, 1'b0);
        end
        flush();

        section = "shadow";
        t = px(1, 1, 512, 100, 0, 100, 700, 100, 7, 8, 9, 7, 8, 9, 1); t.id = 0;
        step(t, 1'b0);
        t = px(0, 3, 1023, 1023, 0, 100, 700, 100, 7, 8, 9, 7, 8, 9, 1); t.id = 1;
        step(t, 1'b0);
        t = px(0, 3, 0, 0, 0, 700, 700, 700, 7, 8, 9, 700, 700, 700, 0); t.id = 2;
        step(t, 1'b0);
        t = px(1, 2, 0, 0, 0, 100, 700, 100, 7, 8, 9, 0, 0, 0, 0); t.v = 1'b0; t.id = 3;
        step(t, 1'b0);
        t = px(0, 3, 1023, 1023, 0, 100, 700, 100, 7, 8, 9, 7, 8, 9, 1); t.id = 4;
        step(t, 1'b0);
        t = px(1, 3, 512, 100, 0, 100, 700, 100, 7, 8, 9, 1023, 1023, 1023, 1); t.id = 5;
        step(t, 1'b0);
        t = px(0, 1, 0, 0, 0, 700, 700, 700, 7, 8, 9, 0, 0, 0, 0); t.id = 6;
        step(t, 1'b0);
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
